// File: rtl/exe_mem_stage_pkg.sv
// Shared definitions for the EXE/MEM boundary: bus widths, zero constants, memory op codes.
// Latency: none (declarations only).
// Backpressure: n/a.
package exe_mem_stage_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned MopBus     = 3;

  localparam logic [RegBus-1:0]     ZeroWord = '0;
  localparam logic [RegAddrBus-1:0] ZeroReg  = '0;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  // Bit 2 selects zero-extension for loads; bits 1:0 give the access size.
  // Stores reuse the size codes since mem_we already tells them apart.
  localparam logic [MopBus-1:0] MEM_OP_LB  = 3'b000;
  localparam logic [MopBus-1:0] MEM_OP_LH  = 3'b001;
  localparam logic [MopBus-1:0] MEM_OP_LW  = 3'b010;
  localparam logic [MopBus-1:0] MEM_OP_LBU = 3'b100;
  localparam logic [MopBus-1:0] MEM_OP_LHU = 3'b101;
  localparam logic [MopBus-1:0] MEM_OP_SB  = 3'b000;
  localparam logic [MopBus-1:0] MEM_OP_SH  = 3'b001;
  localparam logic [MopBus-1:0] MEM_OP_SW  = 3'b010;

endpackage

// File: rtl/exe_mem_stage_pipe_skid_buf.sv
// Generic valid/ready pipeline register with optional 2-entry skid and synchronous flush.
// Latency: 1 cycle in both modes.
// Backpressure: SKID=0 ready is combinational from out_ready_i; SKID=1 ready is a flop (!skid valid).
module pipe_skid_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SKID  = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             main_vld_q, main_vld_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             main_we;

  generate
    if (SKID == 0) begin : g_single
      logic in_fire;

      assign in_ready_o = !main_vld_q | out_ready_i;
      assign in_fire    = in_valid_i & in_ready_o;

      // Single entry: a new accept refills the slot even while the old head drains.
      always_comb begin
        main_d     = in_data_i;
        main_we    = in_fire & !flush_i;
        main_vld_d = main_vld_q;
        if (flush_i) begin
          main_vld_d = 1'b0;
        end else if (in_fire) begin
          main_vld_d = 1'b1;
        end else if (out_ready_i) begin
          main_vld_d = 1'b0;
        end
      end
    end else begin : g_skid
      logic             skid_vld_q, skid_vld_d;
      logic [WIDTH-1:0] skid_q;
      logic             skid_we;
      logic             in_fire;
      logic             drain;

      // Ready is the inverted skid flag, so it never depends on out_ready_i this cycle.
      assign in_ready_o = !skid_vld_q;
      assign in_fire    = in_valid_i & !skid_vld_q;
      assign drain      = main_vld_q & out_ready_i;

      // Steer accepts to main when it frees up this cycle, otherwise park in skid.
      always_comb begin
        main_d     = in_data_i;
        main_we    = 1'b0;
        main_vld_d = main_vld_q;
        skid_we    = 1'b0;
        skid_vld_d = skid_vld_q;
        if (flush_i) begin
          main_vld_d = 1'b0;
          skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
          if (drain) begin
            main_d     = skid_q;
            main_we    = 1'b1;
            skid_vld_d = 1'b0;
          end
        end else if (in_fire) begin
          if (!main_vld_q || drain) begin
            main_we    = 1'b1;
            main_vld_d = 1'b1;
          end else begin
            skid_we    = 1'b1;
            skid_vld_d = 1'b1;
          end
        end else if (drain) begin
          main_vld_d = 1'b0;
        end
      end

      // Skid entry state; payload only loads when the entry is written.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          skid_vld_q <= 1'b0;
          skid_q     <= '0;
        end else begin
          skid_vld_q <= skid_vld_d;
          if (skid_we) begin
            skid_q <= in_data_i;
          end
        end
      end
    end
  endgenerate

  // Main entry state; it is always the head presented downstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_vld_q <= 1'b0;
      main_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      if (main_we) begin
        main_q <= main_d;
      end
    end
  end

  assign out_valid_o = main_vld_q;
  assign out_data_o  = main_q;

endmodule

// File: rtl/exe_mem_stage.sv
// EXE->MEM pipeline boundary carrying writeback fields and a memory request.
// Latency: 1 cycle; throughput 1 per cycle in both SKID modes.
// Backpressure: holds the head stable while out_ready_i is low; in_ready_o drops when full.
module exe_mem_stage
  import exe_mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = RegBus,
  parameter int unsigned RADDR_W = RegAddrBus,
  parameter int unsigned MOP_W   = MopBus,
  parameter int unsigned SKID    = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [RADDR_W-1:0] reg_waddr_i,
  input  logic               reg_we_i,
  input  logic [DATA_W-1:0]  reg_wdata_i,
  input  logic               mem_req_i,
  input  logic               mem_we_i,
  input  logic [MOP_W-1:0]   mem_op_i,
  input  logic [DATA_W-1:0]  mem_addr_i,
  input  logic [DATA_W-1:0]  mem_wdata_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [RADDR_W-1:0] reg_waddr_o,
  output logic               reg_we_o,
  output logic [DATA_W-1:0]  reg_wdata_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [MOP_W-1:0]   mem_op_o,
  output logic [DATA_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0]  mem_wdata_o
);

  localparam int unsigned PW = RADDR_W + 1 + DATA_W + 1 + 1 + MOP_W + DATA_W + DATA_W;

  logic [PW-1:0] in_dat;
  logic [PW-1:0] out_dat;
  logic          head_reg_we;
  logic          head_mem_req;
  logic          head_mem_we;

  assign in_dat = {reg_waddr_i, reg_we_i, reg_wdata_i, mem_req_i,
                   mem_we_i, mem_op_i, mem_addr_i, mem_wdata_i};

  pipe_skid_buf #(
    .WIDTH (PW),
    .SKID  (SKID)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_dat),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_dat)
  );

  assign {reg_waddr_o, head_reg_we, reg_wdata_o, head_mem_req,
          head_mem_we, mem_op_o, mem_addr_o, mem_wdata_o} = out_dat;

  // Side-effecting strobes are qualified so a bubble never writes or issues memory.
  assign reg_we_o  = head_reg_we  & out_valid_o;
  assign mem_req_o = head_mem_req & out_valid_o;
  assign mem_we_o  = head_mem_we  & out_valid_o;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Bench for exe_mem_stage: instance 0 is SKID=0, instance 1 is SKID=1.
// A queue model tracks what each stage should hold and what it should emit.
module tb_exe_mem_stage;
  import exe_mem_stage_pkg::*;

  typedef struct packed {
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic        req;
    logic        mwe;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] mwdata;
  } pl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush[2], in_valid[2], in_ready[2], out_valid[2], out_ready[2];
  logic [4:0]  i_waddr[2], o_waddr[2];
  logic        i_we[2], o_we[2], i_req[2], o_req[2], i_mwe[2], o_mwe[2];
  logic [31:0] i_wdata[2], o_wdata[2], i_addr[2], o_addr[2], i_mwdata[2], o_mwdata[2];
  logic [2:0]  i_op[2], o_op[2];

  int n_chk = 0;
  int n_fail = 0;

  exe_mem_stage #(.SKID(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush[0]),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .reg_waddr_i(i_waddr[0]), .reg_we_i(i_we[0]), .reg_wdata_i(i_wdata[0]),
    .mem_req_i(i_req[0]), .mem_we_i(i_mwe[0]), .mem_op_i(i_op[0]),
    .mem_addr_i(i_addr[0]), .mem_wdata_i(i_mwdata[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .reg_waddr_o(o_waddr[0]), .reg_we_o(o_we[0]), .reg_wdata_o(o_wdata[0]),
    .mem_req_o(o_req[0]), .mem_we_o(o_mwe[0]), .mem_op_o(o_op[0]),
    .mem_addr_o(o_addr[0]), .mem_wdata_o(o_mwdata[0])
  );

  exe_mem_stage #(.SKID(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush[1]),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .reg_waddr_i(i_waddr[1]), .reg_we_i(i_we[1]), .reg_wdata_i(i_wdata[1]),
    .mem_req_i(i_req[1]), .mem_we_i(i_mwe[1]), .mem_op_i(i_op[1]),
    .mem_addr_i(i_addr[1]), .mem_wdata_i(i_mwdata[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .reg_waddr_o(o_waddr[1]), .reg_we_o(o_we[1]), .reg_wdata_o(o_wdata[1]),
    .mem_req_o(o_req[1]), .mem_we_o(o_mwe[1]), .mem_op_o(o_op[1]),
    .mem_addr_o(o_addr[1]), .mem_wdata_o(o_mwdata[1])
  );

  function automatic pl_t get_out(int d);
    return {o_waddr[d], o_we[d], o_wdata[d], o_req[d], o_mwe[d], o_op[d], o_addr[d], o_mwdata[d]};
  endfunction

  function automatic pl_t get_in(int d);
    return {i_waddr[d], i_we[d], i_wdata[d], i_req[d], i_mwe[d], i_op[d], i_addr[d], i_mwdata[d]};
  endfunction

  function automatic pl_t rand_pl();
    pl_t p;
    p.waddr  = 5'($urandom);
    p.we     = 1'($urandom);
    p.wdata  = $urandom;
    p.req    = 1'($urandom);
    p.mwe    = 1'($urandom);
    p.op     = 3'($urandom);
    p.addr   = $urandom;
    p.mwdata = $urandom;
    return p;
  endfunction

  task automatic set_in(int d, pl_t p);
    i_waddr[d]  = p.waddr;
    i_we[d]     = p.we;
    i_wdata[d]  = p.wdata;
    i_req[d]    = p.req;
    i_mwe[d]    = p.mwe;
    i_op[d]     = p.op;
    i_addr[d]   = p.addr;
    i_mwdata[d] = p.mwdata;
  endtask

  task automatic idle(int d);
    in_valid[d]  = 1'b0;
    flush[d]     = 1'b0;
    out_ready[d] = 1'b0;
    set_in(d, '0);
  endtask

  // Reference model: contents of each stage as an ordered queue, plus
  // everything that should have left (exp_dr) and what actually left (act_dr).
  pl_t mq[2][$];
  pl_t exp_dr[2][$];
  pl_t act_dr[2][$];

  function automatic bit model_rdy(int d);
    if (d == 1) return mq[d].size() < 2;
    return (mq[d].size() == 0) || out_ready[d];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq[0].delete();
      mq[1].delete();
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit rdy, pop, push;
        rdy  = model_rdy(d);
        pop  = (mq[d].size() > 0) && out_ready[d];
        push = in_valid[d] && rdy;
        if (pop) begin
          exp_dr[d].push_back(mq[d][0]);
          act_dr[d].push_back(get_out(d));
        end
        if (flush[d]) begin
          mq[d].delete();
        end else begin
          if (pop) void'(mq[d].pop_front());
          if (push) mq[d].push_back(get_in(d));
        end
      end
    end
  end

  task automatic test_reset();
    #2;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_flags d=%0d: valid=%b ready=%b, required valid=0 ready=1", d, out_valid[d], in_ready[d]);
      end
      n_chk++;
      if (get_out(d) !== pl_t'(0)) begin
        n_fail++;
        $display("FAIL reset_payload d=%0d: got %h, required 0", d, get_out(d));
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream(int d);
    pl_t p;
    exp_dr[d].delete();
    act_dr[d].delete();
    out_ready[d] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      p = rand_pl();
      p.waddr = 5'(n);
      p.we    = 1'b1;
      p.wdata = 32'h100 + 32'(n);
      set_in(d, p);
      in_valid[d] = 1'b1;
      #1;
      n_chk++;
      if (in_ready[d] !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_ready d=%0d n=%0d: got %b, required 1", d, n, in_ready[d]);
      end
      @(negedge clk);
      n_chk++;
      if (out_valid[d] !== 1'b1 || o_waddr[d] !== 5'(n) || o_wdata[d] !== 32'h100 + 32'(n)) begin
        n_fail++;
        $display("FAIL stream_head d=%0d n=%0d: valid=%b waddr=%0d wdata=%h, required 1 %0d %h",
                 d, n, out_valid[d], o_waddr[d], o_wdata[d], n, 32'h100 + 32'(n));
      end
    end
    in_valid[d] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (act_dr[d].size() != 8 || out_valid[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_count d=%0d: drained=%0d valid=%b, required 8 and 0", d, act_dr[d].size(), out_valid[d]);
    end
    for (int i = 0; i < act_dr[d].size() && i < 8; i++) begin
      n_chk++;
      if (act_dr[d][i] !== exp_dr[d][i] || act_dr[d][i].waddr !== 5'(i + 1)) begin
        n_fail++;
        $display("FAIL stream_order d=%0d i=%0d: got %h, required %h", d, i, act_dr[d][i], exp_dr[d][i]);
      end
    end
    idle(d);
  endtask

  task automatic test_backpressure();
    pl_t p;
    int guard;
    bit exp_rdy[3] = '{1'b1, 1'b1, 1'b0};
    exp_dr[1].delete();
    act_dr[1].delete();
    out_ready[1] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      p = rand_pl();
      p.waddr = 5'(k);
      set_in(1, p);
      in_valid[1] = 1'b1;
      #1;
      n_chk++;
      if (in_ready[1] !== exp_rdy[k-1]) begin
        n_fail++;
        $display("FAIL bp_ready k=%0d: got %b, required %b", k, in_ready[1], exp_rdy[k-1]);
      end
      @(negedge clk);
    end
    #1;
    n_chk++;
    if (in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1 || o_waddr[1] !== 5'd1) begin
      n_fail++;
      $display("FAIL bp_hold: ready=%b valid=%b waddr=%0d, required 0 1 1", in_ready[1], out_valid[1], o_waddr[1]);
    end
    out_ready[1] = 1'b1;
    guard = 0;
    while (in_ready[1] !== 1'b1 && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    @(negedge clk);
    in_valid[1] = 1'b0;
    while (out_valid[1] !== 1'b0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    n_chk++;
    if (guard >= 40 || act_dr[1].size() != 3) begin
      n_fail++;
      $display("FAIL bp_drain: drained=%0d guard=%0d, required 3 within bound", act_dr[1].size(), guard);
    end
    for (int i = 0; i < act_dr[1].size() && i < 3; i++) begin
      n_chk++;
      if (act_dr[1][i].waddr !== 5'(i + 1)) begin
        n_fail++;
        $display("FAIL bp_order i=%0d: got waddr %0d, required %0d", i, act_dr[1][i].waddr, i + 1);
      end
    end
    idle(1);
  endtask

  task automatic test_flush();
    pl_t p;
    // SKID=1: both entries full, flush collides with a new accept.
    exp_dr[1].delete();
    act_dr[1].delete();
    out_ready[1] = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      p = rand_pl();
      p.waddr = 5'(k);
      set_in(1, p);
      in_valid[1] = 1'b1;
      @(negedge clk);
    end
    p = rand_pl();
    p.waddr = 5'd9;
    p.we    = 1'b1;
    set_in(1, p);
    flush[1] = 1'b1;
    @(negedge clk);
    flush[1]    = 1'b0;
    in_valid[1] = 1'b0;
    #1;
    n_chk++;
    if (out_valid[1] !== 1'b0 || o_we[1] !== 1'b0 || o_req[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_skid: valid=%b we=%b req=%b ready=%b, required 0 0 0 1",
               out_valid[1], o_we[1], o_req[1], in_ready[1]);
    end
    out_ready[1] = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if (act_dr[1].size() != 0) begin
      n_fail++;
      $display("FAIL flush_skid_leak: drained=%0d, required 0", act_dr[1].size());
    end
    idle(1);

    // SKID=0: head handshakes in the flush cycle and is consumed exactly once.
    exp_dr[0].delete();
    act_dr[0].delete();
    out_ready[0] = 1'b1;
    p = rand_pl();
    p.waddr = 5'd4;
    set_in(0, p);
    in_valid[0] = 1'b1;
    @(negedge clk);
    p.waddr = 5'd9;
    set_in(0, p);
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0]    = 1'b0;
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (act_dr[0].size() != 1 || out_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_single: drained=%0d valid=%b, required 1 0", act_dr[0].size(), out_valid[0]);
    end else begin
      n_chk++;
      if (act_dr[0][0].waddr !== 5'd4) begin
        n_fail++;
        $display("FAIL flush_single_head: got waddr %0d, required 4", act_dr[0][0].waddr);
      end
    end
    idle(0);
  endtask

  task automatic test_bubble();
    for (int d = 0; d < 2; d++) begin
      pl_t p = rand_pl();
      p.we  = 1'b1;
      p.req = 1'b1;
      p.mwe = 1'b1;
      set_in(d, p);
      in_valid[d] = 1'b0;
      for (int c = 0; c < 3; c++) begin
        out_ready[d] = 1'($urandom);
        @(negedge clk);
        #1;
        n_chk++;
        if (out_valid[d] !== 1'b0 || o_we[d] !== 1'b0 || o_req[d] !== 1'b0 || o_mwe[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL bubble d=%0d: valid=%b we=%b req=%b mwe=%b, required all 0",
                   d, out_valid[d], o_we[d], o_req[d], o_mwe[d]);
        end
      end
      idle(d);
    end
  endtask

  task automatic test_store(int d);
    pl_t st;
    st = '0;
    st.req    = 1'b1;
    st.mwe    = 1'b1;
    st.op     = MEM_OP_SW;
    st.addr   = 32'h8000_0004;
    st.mwdata = 32'hDEAD_BEEF;
    st.wdata  = 32'h1234_5678;
    exp_dr[d].delete();
    act_dr[d].delete();
    out_ready[d] = 1'b0;
    set_in(d, st);
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
    set_in(d, rand_pl());
    for (int c = 0; c < 5; c++) begin
      #1;
      n_chk++;
      if (out_valid[d] !== 1'b1 || get_out(d) !== st) begin
        n_fail++;
        $display("FAIL store_hold d=%0d c=%0d: valid=%b out=%h, required 1 %h", d, c, out_valid[d], get_out(d), st);
      end
      @(negedge clk);
      set_in(d, rand_pl());
    end
    out_ready[d] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (act_dr[d].size() != 1 || out_valid[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL store_once d=%0d: drained=%0d valid=%b, required 1 0", d, act_dr[d].size(), out_valid[d]);
    end else begin
      n_chk++;
      if (act_dr[d][0] !== st) begin
        n_fail++;
        $display("FAIL store_payload d=%0d: got %h, required %h", d, act_dr[d][0], st);
      end
    end
    idle(d);
  endtask

  task automatic test_random(int d);
    exp_dr[d].delete();
    act_dr[d].delete();
    for (int c = 0; c < 300; c++) begin
      set_in(d, rand_pl());
      in_valid[d]  = ($urandom % 4) != 0;
      out_ready[d] = ($urandom % 3) != 0;
      flush[d]     = ($urandom % 29) == 0;
      #1;
      n_chk++;
      if (in_ready[d] !== model_rdy(d) || out_valid[d] !== (mq[d].size() > 0)) begin
        n_fail++;
        $display("FAIL rand_flags d=%0d c=%0d: ready=%b valid=%b, required %b %b",
                 d, c, in_ready[d], out_valid[d], model_rdy(d), mq[d].size() > 0);
      end
      if (mq[d].size() > 0) begin
        n_chk++;
        if (get_out(d) !== mq[d][0]) begin
          n_fail++;
          $display("FAIL rand_head d=%0d c=%0d: got %h, required %h", d, c, get_out(d), mq[d][0]);
        end
      end else begin
        n_chk++;
        if (o_we[d] !== 1'b0 || o_req[d] !== 1'b0 || o_mwe[d] !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_gate d=%0d c=%0d: we=%b req=%b mwe=%b, required 0", d, c, o_we[d], o_req[d], o_mwe[d]);
        end
      end
      @(negedge clk);
    end
    in_valid[d]  = 1'b0;
    flush[d]     = 1'b0;
    out_ready[d] = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if (act_dr[d].size() != exp_dr[d].size() || out_valid[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_count d=%0d: drained=%0d, required %0d", d, act_dr[d].size(), exp_dr[d].size());
    end
    for (int i = 0; i < act_dr[d].size() && i < exp_dr[d].size(); i++) begin
      if (act_dr[d][i] !== exp_dr[d][i]) begin
        n_chk++;
        n_fail++;
        $display("FAIL rand_order d=%0d i=%0d: got %h, required %h", d, i, act_dr[d][i], exp_dr[d][i]);
      end
    end
    idle(d);
  endtask

  task automatic test_async_reset();
    pl_t p;
    out_ready[1] = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      p = rand_pl();
      p.waddr = 5'(k + 20);
      p.we    = 1'b1;
      set_in(1, p);
      in_valid[1] = 1'b1;
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || get_out(d) !== pl_t'(0)) begin
        n_fail++;
        $display("FAIL async_reset d=%0d: valid=%b ready=%b out=%h, required 0 1 0",
                 d, out_valid[d], in_ready[d], get_out(d));
      end
    end
    @(negedge clk);
    in_valid[1] = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b ready=%b, required 0 1", out_valid[1], in_ready[1]);
    end
    idle(1);
  endtask

  initial begin
    rst_n = 1'b1;
    idle(0);
    idle(1);
    #1 rst_n = 1'b0;
    test_reset();
    @(negedge clk);
    test_stream(0);
    test_stream(1);
    test_backpressure();
    test_flush();
    test_bubble();
    test_store(0);
    test_store(1);
    test_random(0);
    test_random(1);
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
